seg7_scan_counter: RTL
======================

// Module: seg7_scan_counter
// PURPOSE
//  Multi-digit, time-multiplexed seven-segment driver with built-in incrementing counter.
//  Holds an N-digit value, loaded in parallel or stepped by an increment strobe.
//  Scans one digit per refresh tick, decoding it through a shared glyph table.
//  Sits between user logic (counters, UART, buttons) and the board's digit/segment pins.
// PARAMETERS
//  NUM_DIGITS     4      digits scanned (1..8)
//  SCAN_DIV       12000  clk cycles per digit slot (12 MHz -> 1 kHz digit rate); >=2
//  HEX            0      0: BCD digits, radix 10; 1: hex digits, radix 16
//  SEG_ACTIVE_LOW 1      1: segment lit when pin=0 (common anode)
//  DIG_ACTIVE_LOW 1      1: digit enabled when pin=0
//  BLANK_LEADING  1      1: suppress leading zeros
// PORTS
//  clk         in   1               system clock
//  rst_n       in   1               asynchronous active-low reset
//  enable      in   1               0: display dark, scan holds
//  load        in   1               1-cycle strobe: value <= data_in
//  data_in     in   4*NUM_DIGITS    nibble k = digit k (digit 0 = least significant)
//  inc         in   1               1-cycle strobe: value <= value+1 (radix per HEX)
//  dp_in       in   NUM_DIGITS      decimal point per digit, sampled with load
//  seg         out  7               {a,b,c,d,e,f,g}, seg[6]=a
//  dp          out  1               decimal point of current digit
//  dig_sel     out  NUM_DIGITS      one-hot digit enable (polarity per DIG_ACTIVE_LOW)
//  frame_done  out  1               1-cycle pulse at end of each full scan
//  ovf         out  1               1-cycle pulse when inc wraps max -> 0
// BEHAVIOUR
//  Reset: value=0, dp reg=0, shadow=0, idx=0, prescaler=0; seg/dp/dig_sel at inactive level.
//   frame_done=0, ovf=0.
//  Value update: load has priority over inc in the same cycle (inc is dropped, no ovf).
//  inc: ripple increment across digits; digit at radix-1 -> 0 with carry.
//   HEX=0 nibbles >9 (from load) step to 0 with carry.
//   All digits at max -> all 0, ovf pulses the cycle after inc.
//  Prescaler counts 0..SCAN_DIV-1 while enable=1. tick = (prescaler==SCAN_DIV-1).
//   On tick, idx advances; NUM_DIGITS-1 wraps to 0.
//  On the wrap tick:
//   - frame_done pulses for one cycle.
//   - shadow <= {value, dp reg}.
//   Display reads only shadow: no tearing mid-frame; load/inc shown from next frame.
//  Outputs are registered, one cycle after idx: dig_sel has bit idx active; seg = glyph(shadow[idx]).
//  Leading zeros (BLANK_LEADING=1): digit k is blanked when it and every more significant digit are 0.
//   Digit 0 is never blanked. A blanked digit has segs off; its dp still shows.
//  HEX=0, nibble >9: all segments off. HEX=1: glyphs 0-9, A,b,C,d,E,F.
//  Dead time: in the cycle after tick, dig_sel is all inactive before the new digit is driven.
//  enable=0: from the next cycle seg/dp/dig_sel go inactive. Prescaler and idx hold.
//   load/inc still act. Scan resumes on re-enable from the held state.
//  rst_n asserted mid-scan: immediate return to reset state. Pending load/inc is lost.
// STRUCTURE
//  Package seg7_pkg:
//   - segment bit-index constants SEG_A..SEG_G
//   - 16-entry active-high glyph table (function seg7_glyph_f)
//   - BLANK constant 7'b0
//  Sub-module seg7_glyph: combinational nibble + hex_en -> 7-bit active-high pattern.
//   Polarity inversion is done only at the output registers of this block.
//  Top holds the value counter, shadow register, prescaler, scan index and output registers.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=4, HEX=0, both polarities low)
//  Reset release, enable=1: within 1 frame dig_sel cycles 1110,1101,1011,0111.
//   Digit0 seg=7'b0000001 ("0"); digits 1-3 segs all 1 (blanked).
//  load data_in=16'h0429, dp_in=4'b0010: next frame shows 9,2,4 then blank.
//   dp=0 only on digit1. No change visible before frame_done.
//  load 16'h9999 then inc: value=0000, ovf pulses 1 cycle. load+inc same cycle: value=data_in, no ovf.
//  HEX=1 build, load 16'h00AF: digit0 glyph F (7'b0111000), digit1 A (7'b0001000).
//  enable=0 mid-frame for 10 cycles: outputs inactive, idx frozen, resumes at same digit.
//  Async rst_n pulse mid-frame (no clk edge): outputs inactive immediately, frame_done=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions and the
// active-high glyph table used by the scan driver.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] BLANK = 7'b0000000;

    // Patterns are {a,b,c,d,e,f,g}, 1 = segment lit.
    function automatic logic [6:0] seg7_glyph_f(input logic [3:0] nib);
        logic [6:0] g;
        g = BLANK;
        case (nib)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b0011111;
            4'hC: g = 7'b1001110;
            4'hD: g = 7'b0111101;
            4'hE: g = 7'b1001111;
            4'hF: g = 7'b1000111;
            default: g = BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Nibble to active-high segment pattern; in decimal mode the
// non-BCD codes render dark.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_en,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = seg7_glyph_f(nibble);
        if (!hex_en && (nibble > 4'd9))
            pattern = BLANK;
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// Multiplexed N-digit seven-segment driver with a loadable, incrementing
// value; the scan reads a per-frame shadow copy so frames never tear.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 12000,
    parameter int HEX            = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    inc,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done,
    output logic                    ovf
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int VW    = 4 * NUM_DIGITS;

    localparam logic [3:0] MAX_DIGIT = (HEX != 0) ? 4'd15 : 4'd9;
    localparam logic [6:0] SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic       DP_OFF    = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [VW-1:0]         value;
    logic [NUM_DIGITS-1:0] dp_reg;
    logic [VW-1:0]         shadow_val;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;

    logic                  tick;
    logic                  last;
    logic [VW-1:0]         inc_val;
    logic                  inc_carry;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  cur_dp;
    logic [6:0]            glyph;
    logic [6:0]            pat;
    logic [NUM_DIGITS-1:0] onehot;

    assign tick = enable && (presc == PRE_W'(SCAN_DIV - 1));
    assign last = (idx == IDX_W'(NUM_DIGITS - 1));

    // Ripple increment; codes above the radix maximum also wrap with carry.
    always_comb begin
        logic [3:0] nib;
        inc_val   = value;
        inc_carry = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib = value[4*k +: 4];
            if (inc_carry) begin
                if (nib >= MAX_DIGIT) begin
                    nib = 4'd0;
                end else begin
                    nib       = nib + 4'd1;
                    inc_carry = 1'b0;
                end
            end
            inc_val[4*k +: 4] = nib;
        end
    end

    // A digit is a leading zero when it and all higher digits are zero.
    always_comb begin
        logic zero_run;
        blank_vec = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (shadow_val[4*k +: 4] == 4'd0);
            blank_vec[k] = zero_run && (k != 0) && (BLANK_LEADING != 0);
        end
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = shadow_val[4*k +: 4];
                cur_blank = blank_vec[k];
                cur_dp    = shadow_dp[k];
            end
        end
    end

    seg7_glyph u_glyph (
        .nibble  (cur_nib),
        .hex_en  (HEX != 0),
        .pattern (glyph)
    );

    assign pat    = cur_blank ? BLANK : glyph;
    assign onehot = NUM_DIGITS'(1) << idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value  <= '0;
            dp_reg <= '0;
            ovf    <= 1'b0;
        end else if (load) begin
            value  <= data_in;
            dp_reg <= dp_in;
            ovf    <= 1'b0;
        end else if (inc) begin
            value  <= inc_val;
            ovf    <= inc_carry;
        end else begin
            ovf    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick && last;
            if (tick) begin
                presc <= '0;
                idx   <= last ? '0 : idx + IDX_W'(1);
                if (last) begin
                    shadow_val <= value;
                    shadow_dp  <= dp_reg;
                end
            end else if (enable) begin
                presc <= presc + PRE_W'(1);
            end
        end
    end

    // Tick cycle drives everything dark, giving one cycle of digit dead time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= SEG_OFF;
            dp      <= DP_OFF;
            dig_sel <= DIG_OFF;
        end else if (!enable || tick) begin
            seg     <= SEG_OFF;
            dp      <= DP_OFF;
            dig_sel <= DIG_OFF;
        end else begin
            seg     <= (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
            dp      <= cur_dp ^ DP_OFF;
            dig_sel <= (DIG_ACTIVE_LOW != 0) ? ~onehot : onehot;
        end
    end

endmodule
